// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad FSM state encoding, key code constants
// and small keypad decode helpers.
package calc_pkg;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  // Digits 0-9 use their own value as key code; the top row of codes are operators.
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  function automatic logic [1:0] first_low_col(input logic [3:0] cols_n);
    logic [1:0] idx;
    if (!cols_n[0]) begin
      idx = 2'd0;
    end else if (!cols_n[1]) begin
      idx = 2'd1;
    end else if (!cols_n[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows_n);
    logic [1:0] idx;
    case (rows_n)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned        WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: rotates the active-low row drive on each btnclk
// rising edge, debounces presses/releases and reports one key_valid per press.
module keypad_scan_debounce
  import calc_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 2,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btnclk,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_down
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_TICKS);

  logic [COLS-1:0] col_s;
  logic            btnclk_q;
  logic            tick_s;
  logic            any_low_s;
  logic            latched_low_s;
  logic            deb_hit_s;

  logic [1:0]      state_q, state_d;
  logic [ROWS-1:0] row_n_q, row_n_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      deb_cnt_q, deb_cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_down_q, key_down_d;

  sync_2ff #(
    .WIDTH    (COLS),
    .RESET_VAL({COLS{1'b1}})
  ) u_col_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (col_n),
    .q_o  (col_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnclk_q <= 1'b0;
    end else begin
      btnclk_q <= btnclk;
    end
  end

  assign tick_s        = btnclk & ~btnclk_q;
  assign any_low_s     = ~&col_s;
  assign latched_low_s = ~col_s[col_idx_q];
  assign deb_hit_s     = (deb_cnt_q + 4'd1) == DEB_MAX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (any_low_s) begin
            state_d = DEBOUNCE;
          end else begin
            state_d = SCAN;
          end
        end
        DEBOUNCE: begin
          if (!latched_low_s) begin
            state_d = SCAN;
          end else if (deb_hit_s) begin
            state_d = HELD;
          end else begin
            state_d = DEBOUNCE;
          end
        end
        HELD: begin
          if (!latched_low_s && deb_hit_s) begin
            state_d = SCAN;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Row drive, debounce counter and key outputs; key_valid self-clears every clk.
  always_comb begin
    row_n_d     = row_n_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (any_low_s) begin
            row_idx_d = row_index(row_n_q);
            col_idx_d = first_low_col(col_s);
            deb_cnt_d = 4'd1;
          end else begin
            row_n_d = {row_n_q[ROWS-2:0], row_n_q[ROWS-1]};
          end
        end
        DEBOUNCE: begin
          if (!latched_low_s) begin
            deb_cnt_d = 4'd0;
          end else if (deb_hit_s) begin
            key_code_d  = {row_idx_q, col_idx_q};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            deb_cnt_d   = 4'd0;
          end else begin
            deb_cnt_d = deb_cnt_q + 4'd1;
          end
        end
        HELD: begin
          if (latched_low_s) begin
            deb_cnt_d = 4'd0;
          end else if (deb_hit_s) begin
            key_down_d = 1'b0;
            deb_cnt_d  = 4'd0;
            row_n_d    = {row_n_q[ROWS-2:0], row_n_q[ROWS-1]};
          end else begin
            deb_cnt_d = deb_cnt_q + 4'd1;
          end
        end
        default: begin
          deb_cnt_d = 4'd0;
        end
      endcase
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_n_q     <= {{(ROWS-1){1'b1}}, 1'b0};
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      deb_cnt_q   <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      row_n_q     <= row_n_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce: a simulated key matrix, a
// tick-level press/release model feeding an expectation queue, and a monitor.
module tb_keypad_scan_debounce;

  localparam int DEB = 2;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnclk;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [3:0] pressed [4];
  exp_t       exp_q [$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       prev_valid = 1'b0;

  // model: candidate key, held key, run length of matching samples, scanned row
  bit m_cand, m_held;
  int run, mrow, mcol;

  keypad_scan_debounce #(.DEB_TICKS(DEB), .ROWS(4), .COLS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnclk   (btnclk),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical matrix: a column reads low when a pressed key sits on a driven row.
  always_comb begin
    logic [3:0] cv;
    cv = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[r][c] && !row_n[r]) cv[c] = 1'b0;
      end
    end
    col_n = cv;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid actual_code=%0h expected=none", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e.code || cyc != e.cyc) begin
          failures++;
          $display("FAIL valid_pulse actual code=%0h cyc=%0d expected code=%0h cyc=%0d",
                   key_code, cyc, e.code, e.cyc);
        end
      end
      if (prev_valid) begin
        failures++;
        $display("FAIL valid_width actual=2+ clks expected=1 clk");
      end
    end
    prev_valid <= (key_valid === 1'b1);
  end

  task automatic model_reset();
    m_cand = 0; m_held = 0; run = 0; mrow = 0; mcol = 0;
  endtask

  task automatic model_step(input int ecyc);
    logic [3:0] low;
    exp_t e;
    low = pressed[mrow];
    if (m_held) begin
      if (!low[mcol]) begin
        run++;
        if (run == DEB) begin m_held = 0; run = 0; mrow = (mrow + 1) % 4; end
      end else run = 0;
    end else if (m_cand) begin
      if (low[mcol]) begin
        run++;
        if (run == DEB) begin
          m_held = 1; m_cand = 0; run = 0;
          e.code = 4'(mrow * 4 + mcol);
          e.cyc  = ecyc;
          exp_q.push_back(e);
        end
      end else begin
        m_cand = 0; run = 0;
      end
    end else if (low != 4'd0) begin
      m_cand = 1; run = 1;
      for (int c = 3; c >= 0; c--) if (low[c]) mcol = c;
    end else begin
      mrow = (mrow + 1) % 4;
    end
  endtask

  function automatic logic [3:0] exp_row();
    logic [3:0] one;
    one = 4'b0001 << mrow;
    return ~one;
  endfunction

  task automatic do_tick();
    repeat (4) @(negedge clk);
    btnclk = 1'b1;
    model_step(cyc + 1);
    repeat (8) @(negedge clk);
    btnclk = 1'b0;
    repeat (2) @(negedge clk);
    check("row_n", row_n, exp_row());
    check("key_down", key_down, m_held);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c, n;
    rst = 1'b1;
    btnclk = 1'b0;
    release_all();
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_down", key_down, 1'b0);
    rst = 1'b0;

    // scan rotation with no keys
    repeat (5) do_tick();

    // clean press row 2 col 1
    pressed[2][1] = 1'b1;
    repeat (8) do_tick();
    check("press_code", key_code, 4'h9);
    check("press_row_held", row_n, 4'b1011);
    release_all();
    repeat (4) do_tick();

    // single-tick bounce on row 0 col 3
    for (int k = 0; k < 4 && mrow != 0; k++) do_tick();
    pressed[0][3] = 1'b1;
    do_tick();
    pressed[0][3] = 1'b0;
    repeat (3) do_tick();

    // hold key 0, release with one bounce
    pressed[0][0] = 1'b1;
    repeat (10) do_tick();
    check("hold_down", key_down, 1'b1);
    pressed[0][0] = 1'b0; do_tick();
    pressed[0][0] = 1'b1; do_tick();
    pressed[0][0] = 1'b0;
    repeat (4) do_tick();

    // multi-key on row 3, then a second key while held
    pressed[3] = 4'b0110;
    repeat (7) do_tick();
    check("multi_code", key_code, 4'hD);
    pressed[1][0] = 1'b1;
    repeat (3) do_tick();
    release_all();
    repeat (4) do_tick();

    // btnclk stuck low: nothing moves
    begin
      logic [3:0] row_before;
      row_before = row_n;
      repeat (40) @(negedge clk);
      check("stuck_row", row_n, row_before);
    end

    // reset while debouncing a press on row 1
    for (int k = 0; k < 4 && mrow != 1; k++) do_tick();
    pressed[1][2] = 1'b1;
    repeat (4) @(negedge clk);
    btnclk = 1'b1;
    model_step(cyc + 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_row_n", row_n, 4'b1110);
    check("midrst_key_code", key_code, 4'h0);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_key_down", key_down, 1'b0);
    model_reset();
    repeat (6) @(negedge clk);
    btnclk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) do_tick();
    check("redetect_code", key_code, 4'h6);
    release_all();
    repeat (4) do_tick();

    // randomized presses, bounces and extra keys
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pressed[r][c] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) pressed[r][c] = ~pressed[r][c];
        do_tick();
      end
      release_all();
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) do_tick();
    end
    release_all();
    repeat (4) do_tick();

    repeat (4) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
